// File: rtl/rst_seq_watchdog.sv
// rst_seq_watchdog: reset sequencer with a run watchdog.
//   Holds NUM_DOMAINS active-low domain resets low for HOLD_CYCLES edges.
//   It then releases them one at a time, STAGGER_CYCLES apart.
//   After the last release it supervises the run with a kick/timeout watchdog.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sw_rst     synchronous restart of the sequence from HOLD (pulse or level)
//   kick       watchdog refresh while running
//   pass       run-complete indication; accepted only while running
//   rstn_out   active-low domain resets, bit i drives domain i
//   busy       high in HOLD / RELEASE
//   running    high in RUN
//   done       sticky, pass accepted
//   timeout    sticky, watchdog expired
//   run_cycles edges spent in RUN (only with RST_SEQ_WATCHDOG_CYCLE_COUNT_EN)
//
// Optional feature macro: RST_SEQ_WATCHDOG_CYCLE_COUNT_EN adds the run_cycles
// counter and port.
module rst_seq_watchdog #(
   parameter int NUM_DOMAINS    = 2,
   parameter int HOLD_CYCLES    = 4,
   parameter int STAGGER_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int TIMEOUT_ACTION = 0,
   parameter int CNT_W          = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sw_rst,
   input  logic                   kick,
   input  logic                   pass,
   output logic [NUM_DOMAINS-1:0] rstn_out,
   output logic                   busy,
   output logic                   running,
   output logic                   done,
   output logic                   timeout
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
   ,
   output logic [CNT_W-1:0]       run_cycles
`endif
);

   typedef enum logic [2:0] {S_HOLD, S_RELEASE, S_RUN, S_DONE, S_TMO} state_t;

   // seq_cnt value seen on the edge that releases the last domain
   localparam logic [CNT_W-1:0] SEQ_LAST =
      CNT_W'(HOLD_CYCLES + (NUM_DOMAINS-1)*STAGGER_CYCLES - 1);
   localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(WD_EN ? TIMEOUT_CYCLES-1 : 0);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        seq_q, seq_d;
   logic [CNT_W-1:0]        wd_q, wd_d;
   logic [NUM_DOMAINS-1:0]  rstn_d;
   logic [NUM_DOMAINS-1:0]  rel_hit;

   // Domain i is released on the edge where seq_cnt == HOLD + i*STAGGER - 1.
   // With STAGGER=0 every bit hits on the same edge.
   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_rel
      assign rel_hit[i] = (seq_q == CNT_W'(HOLD_CYCLES + i*STAGGER_CYCLES - 1));
   end

   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      wd_d    = wd_q;
      rstn_d  = rstn_out;
      if (sw_rst) begin
         state_d = S_HOLD;
         seq_d   = '0;
         wd_d    = '0;
         rstn_d  = '0;
      end else begin
         case (state_q)
            S_HOLD, S_RELEASE: begin
               rstn_d = rstn_out | rel_hit;
               if (seq_q == SEQ_LAST) begin
                  // last release: seq_cnt saturates here, watchdog starts fresh
                  state_d = S_RUN;
                  wd_d    = '0;
               end else begin
                  seq_d = seq_q + 1'b1;
                  if (state_q == S_HOLD && rel_hit[0]) state_d = S_RELEASE;
               end
            end
            S_RUN: begin
               if (pass) begin
                  state_d = S_DONE;
               end else if (kick) begin
                  wd_d = '0;
               end else if (WD_EN && wd_q == WD_LAST) begin
                  state_d = S_TMO;
                  if (TIMEOUT_ACTION == 1) rstn_d = '0;
               end else if (wd_q != '1) begin
                  // saturate so a disabled watchdog never wraps
                  wd_d = wd_q + 1'b1;
               end
            end
            S_DONE, S_TMO: ;
            default: state_d = S_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_HOLD;
         seq_q    <= '0;
         wd_q     <= '0;
         rstn_out <= '0;
         busy     <= 1'b1;
         running  <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         wd_q     <= wd_d;
         rstn_out <= rstn_d;
         busy     <= (state_d == S_HOLD) || (state_d == S_RELEASE);
         running  <= (state_d == S_RUN);
         done     <= (state_d == S_DONE);
         timeout  <= (state_d == S_TMO);
      end
   end

`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
   // Counts edges taken from RUN, including the exit edge; holds in DONE/TMO.
   always_ff @(posedge clk) begin
      if (rst || sw_rst)                             run_cycles <= '0;
      else if (state_q == S_RUN && run_cycles != '1) run_cycles <= run_cycles + 1'b1;
   end
`endif

endmodule

// File: tb/tb_rst_seq_watchdog.sv
module tb_rst_seq_watchdog;

   logic clk = 1'b0;
   logic rst = 1'b1, sw_rst = 1'b0, kick = 1'b0, pass = 1'b0;

   logic [2:0] m_rstn, t_rstn, n_rstn;
   logic m_busy, m_run, m_done, m_tmo;
   logic t_busy, t_run, t_done, t_tmo;
   logic n_busy, n_run, n_done, n_tmo;
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
   logic [31:0] m_rc, t_rc, n_rc;
`endif

   always #5 clk = ~clk;

   // main build
   rst_seq_watchdog #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
      .TIMEOUT_CYCLES(8), .TIMEOUT_ACTION(0), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .kick(kick), .pass(pass),
      .rstn_out(m_rstn), .busy(m_busy), .running(m_run), .done(m_done), .timeout(m_tmo)
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
      , .run_cycles(m_rc)
`endif
   );

   // timeout reasserts resets
   rst_seq_watchdog #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
      .TIMEOUT_CYCLES(8), .TIMEOUT_ACTION(1), .CNT_W(32)) dut_ta (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .kick(kick), .pass(pass),
      .rstn_out(t_rstn), .busy(t_busy), .running(t_run), .done(t_done), .timeout(t_tmo)
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
      , .run_cycles(t_rc)
`endif
   );

   // no stagger, watchdog disabled
   rst_seq_watchdog #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .STAGGER_CYCLES(0),
      .TIMEOUT_CYCLES(0), .TIMEOUT_ACTION(0), .CNT_W(32)) dut_ns (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .kick(kick), .pass(pass),
      .rstn_out(n_rstn), .busy(n_busy), .running(n_run), .done(n_done), .timeout(n_tmo)
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
      , .run_cycles(n_rc)
`endif
   );

   wire [6:0] m_o = {m_rstn, m_busy, m_run, m_done, m_tmo};
   wire [6:0] t_o = {t_rstn, t_busy, t_run, t_done, t_tmo};
   wire [6:0] n_o = {n_rstn, n_busy, n_run, n_done, n_tmo};

   // {rstn[2:0], busy, running, done, timeout}
   localparam logic [6:0] RST_E  = 7'b000_1_0_0_0;
   localparam logic [6:0] B0_E   = 7'b001_1_0_0_0;
   localparam logic [6:0] B1_E   = 7'b011_1_0_0_0;
   localparam logic [6:0] RUN_E  = 7'b111_0_1_0_0;
   localparam logic [6:0] TMO_E  = 7'b111_0_0_0_1;
   localparam logic [6:0] DONE_E = 7'b111_0_0_1_0;
   localparam logic [6:0] TMOZ_E = 7'b000_0_0_0_1;

   typedef struct {
      logic       rst;
      logic       sw;
      logic       kick;
      logic       pass;
      logic [6:0] exp;
   } vec_t;

   vec_t       tbl[19];
   logic [6:0] sbq[$];
   int         n_tests = 0, n_fail = 0;

   task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (rstn,busy,run,done,tmo)", nm, got, exp);
      end
   endtask

   // drive one edge; expectation queued at drive time, popped after the edge
   task automatic cyc(input string nm, input logic r, input logic sw,
                      input logic k, input logic p, input logic [6:0] e);
      logic [6:0] x;
      @(negedge clk);
      rst = r; sw_rst = sw; kick = k; pass = p;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         x = sbq.pop_front();
         check(nm, m_o, x);
      end
   endtask

   // sequence edges 1..8 after (sw_)rst release; p drives pass/kick to show they are ignored
   task automatic seq_replay(input string nm, input logic p, input int last);
      for (int i = 3; i <= last; i++) cyc(nm, 1'b0, 1'b0, p, p, tbl[i].exp);
   endtask

   initial begin
      for (int i = 0; i < 3; i++)   tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, RST_E};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, RST_E};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, RST_E};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, RST_E};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, B0_E};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, B0_E};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, B1_E};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, B1_E};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, RUN_E};
      for (int i = 11; i < 18; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, RUN_E};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, TMO_E};

      // reset, staggered release, unkicked timeout 8 edges after running rose
      for (int i = 0; i < 19; i++) begin
         cyc("seq_tbl", tbl[i].rst, tbl[i].sw, tbl[i].kick, tbl[i].pass, tbl[i].exp);
         if (i == 5)  check("ns_before_release", n_o, RST_E);
         if (i == 6)  check("ns_all_release", n_o, RUN_E);
         if (i == 17) check("ta_before_tmo", t_o, RUN_E);
         if (i == 18) check("ta_tmo_reassert", t_o, TMOZ_E);
      end

      // sw_rst in TMO clears timeout, sequence restarts with same timing
      cyc("sw_in_tmo", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_after_tmo", 1'b0, 10);

      // kick every 5 edges for 40 edges, then pass
      for (int k = 1; k <= 40; k++) cyc("kick_run", 1'b0, 1'b0, (k % 5) == 0, 1'b0, RUN_E);
      cyc("pass", 1'b0, 1'b0, 1'b0, 1'b1, DONE_E);
`ifdef RST_SEQ_WATCHDOG_CYCLE_COUNT_EN
      n_tests++;
      if (m_rc !== 32'd41) begin
         n_fail++;
         $display("FAIL run_cycles: got %0d expected 41", m_rc);
      end
`endif
      cyc("done_kick", 1'b0, 1'b0, 1'b1, 1'b0, DONE_E);
      cyc("done_pass", 1'b0, 1'b0, 1'b0, 1'b1, DONE_E);
      for (int k = 0; k < 10; k++) cyc("done_idle", 1'b0, 1'b0, 1'b0, 1'b0, DONE_E);

      // pass on the expiry edge wins
      cyc("sw_pulse", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_d1", 1'b0, 10);
      for (int k = 0; k < 7; k++) cyc("run_d1", 1'b0, 1'b0, 1'b0, 1'b0, RUN_E);
      cyc("pass_at_expiry", 1'b0, 1'b0, 1'b0, 1'b1, DONE_E);

      // kick on the expiry edge keeps running, then a full period to timeout
      cyc("sw_pulse", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_d2", 1'b0, 10);
      for (int k = 0; k < 7; k++) cyc("run_d2", 1'b0, 1'b0, 1'b0, 1'b0, RUN_E);
      cyc("kick_at_expiry", 1'b0, 1'b0, 1'b1, 1'b0, RUN_E);
      for (int k = 0; k < 7; k++) cyc("run_after_kick", 1'b0, 1'b0, 1'b0, 1'b0, RUN_E);
      cyc("tmo_after_kick", 1'b0, 1'b0, 1'b0, 1'b0, TMO_E);
      cyc("tmo_ignores", 1'b0, 1'b0, 1'b1, 1'b1, TMO_E);

      // sw_rst during RELEASE; restart with pass/kick held high (ignored)
      cyc("sw_pulse", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_partial", 1'b0, 7);
      cyc("sw_in_release", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_ignore_in", 1'b1, 10);

      // held sw_rst stays in HOLD; counting starts after release
      for (int k = 0; k < 3; k++) cyc("sw_held", 1'b0, 1'b1, 1'b0, 1'b0, RST_E);
      seq_replay("seq_after_held", 1'b0, 10);

      // 1000 idle edges: main times out, disabled watchdog never does
      for (int k = 1; k <= 1000; k++)
         cyc("idle_long", 1'b0, 1'b0, 1'b0, 1'b0, (k < 8) ? RUN_E : TMO_E);
      check("ns_no_timeout", n_o, RUN_E);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
